// File: rtl/pipe_barrel_shifter_if.sv
// Handshake bus for pipe_barrel_shifter: input beat (operand, distance, mode)
// and output beat (result plus zero/error flags), both valid/ready.
interface pipe_barrel_shifter_if #(
    parameter int WIDTH = 8
);
    localparam int SHW = $clog2(WIDTH);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] data_in;
    logic [SHW-1:0]   shift_amt;
    logic [2:0]       mode;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] data_out;
    logic             zero_out;
    logic             err_out;

    modport master (
        output in_valid, data_in, shift_amt, mode, out_ready,
        input  in_ready, out_valid, data_out, zero_out, err_out
    );

    modport slave (
        input  in_valid, data_in, shift_amt, mode, out_ready,
        output in_ready, out_valid, data_out, zero_out, err_out
    );
endinterface

// File: rtl/pipe_barrel_shifter.sv
// Pipelined logarithmic barrel shifter: stage k applies a 2^k shift when bit k
// of the distance is set; the last stage is the registered output.
module pipe_barrel_shifter #(
    parameter int WIDTH = 8
) (
    input logic                  clk,
    input logic                  rst,
    pipe_barrel_shifter_if.slave bus
);
    localparam int SHW = $clog2(WIDTH);

    localparam logic [2:0] MODE_LSL = 3'd0;
    localparam logic [2:0] MODE_LSR = 3'd1;
    localparam logic [2:0] MODE_ASR = 3'd2;
    localparam logic [2:0] MODE_ROL = 3'd3;
    localparam logic [2:0] MODE_ROR = 3'd4;

    function automatic logic [WIDTH-1:0] shift_step(
        input logic [WIDTH-1:0] d,
        input logic [2:0]       m,
        input int               k
    );
        int n;
        logic [WIDTH-1:0] r;
        n = 1 << k;
        case (m)
            MODE_LSL: r = d << n;
            MODE_LSR: r = d >> n;
            // Sign fill from the current MSB equals the original MSB, since
            // every earlier ASR stage already replicated it.
            MODE_ASR: r = $unsigned($signed(d) >>> n);
            MODE_ROL: r = (d << n) | (d >> (WIDTH - n));
            MODE_ROR: r = (d >> n) | (d << (WIDTH - n));
            default:  r = d;
        endcase
        return r;
    endfunction

    logic [WIDTH-1:0] data_q  [SHW];
    logic [WIDTH-1:0] data_d  [SHW];
    logic [WIDTH-1:0] src_data[SHW];
    logic [SHW-1:0]   amt_q   [SHW];
    logic [SHW-1:0]   amt_d   [SHW];
    logic [SHW-1:0]   src_amt [SHW];
    logic [2:0]       mode_q  [SHW];
    logic [2:0]       mode_d  [SHW];
    logic [2:0]       src_mode[SHW];
    logic             valid_q [SHW];
    logic             valid_d [SHW];
    logic             src_valid[SHW];
    logic             err_q   [SHW];
    logic             err_d   [SHW];
    logic             src_err [SHW];
    logic             zero_q;
    logic             zero_d;
    logic             advance_s;

    assign advance_s    = !valid_q[SHW-1] || bus.out_ready;
    assign bus.in_ready = advance_s;

    assign bus.out_valid = valid_q[SHW-1];
    assign bus.data_out  = data_q[SHW-1];
    assign bus.err_out   = err_q[SHW-1];
    assign bus.zero_out  = zero_q;

    // Stage inputs: stage 0 takes the bus, stage k takes stage k-1.
    always_comb begin
        src_data[0]  = bus.data_in;
        src_amt[0]   = bus.shift_amt;
        src_mode[0]  = bus.mode;
        src_valid[0] = bus.in_valid;
        src_err[0]   = (bus.mode > MODE_ROR);
        for (int k = 1; k < SHW; k++) begin
            src_data[k]  = data_q[k-1];
            src_amt[k]   = amt_q[k-1];
            src_mode[k]  = mode_q[k-1];
            src_valid[k] = valid_q[k-1];
            src_err[k]   = err_q[k-1];
        end
    end

    // Next-state: every stage moves together on advance, otherwise holds.
    always_comb begin
        for (int k = 0; k < SHW; k++) begin
            data_d[k]  = data_q[k];
            amt_d[k]   = amt_q[k];
            mode_d[k]  = mode_q[k];
            valid_d[k] = valid_q[k];
            err_d[k]   = err_q[k];
        end
        zero_d = zero_q;
        if (advance_s) begin
            for (int k = 0; k < SHW; k++) begin
                valid_d[k] = src_valid[k];
                amt_d[k]   = src_amt[k];
                mode_d[k]  = src_mode[k];
                err_d[k]   = src_err[k];
                if (src_amt[k][k] && !src_err[k]) begin
                    data_d[k] = shift_step(src_data[k], src_mode[k], k);
                end else begin
                    data_d[k] = src_data[k];
                end
            end
            zero_d = (data_d[SHW-1] == '0);
        end else begin
            zero_d = zero_q;
        end
    end

    // Pipeline registers; reset empties every stage and zeroes the output.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < SHW; k++) begin
                data_q[k]  <= '0;
                amt_q[k]   <= '0;
                mode_q[k]  <= 3'd0;
                valid_q[k] <= 1'b0;
                err_q[k]   <= 1'b0;
            end
            zero_q <= 1'b0;
        end else begin
            for (int k = 0; k < SHW; k++) begin
                data_q[k]  <= data_d[k];
                amt_q[k]   <= amt_d[k];
                mode_q[k]  <= mode_d[k];
                valid_q[k] <= valid_d[k];
                err_q[k]   <= err_d[k];
            end
            zero_q <= zero_d;
        end
    end
endmodule
